// File: rtl/echo_pkg.sv
// Shared types and helpers for the multi-tap echo processor.
package echo_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    localparam logic [2:0] GAIN_MUTE = 3'd7;

    // Clamp a signed value to the range of a w-bit two's-complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                      input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/multitap_echo_if.sv
// Sample/tap-control bus of the multi-tap echo processor.
interface multitap_echo_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned N_TAPS = 4
);
    logic                       sample_tick;
    logic [DATA_W-1:0]          data_in;
    logic [N_TAPS*ADDR_W-1:0]   tap_delay;
    logic [N_TAPS*3-1:0]        tap_gain;
    logic [DATA_W-1:0]          data_out;
    logic                       out_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output sample_tick, data_in, tap_delay, tap_gain,
        input  data_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, data_in, tap_delay, tap_gain,
        output data_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/echo_ram.sv
// Simple dual-port synchronous RAM (1-cycle read latency, no reset) for the echo delay line.
module echo_ram #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/multitap_echo.sv
// Multi-tap echo: dry sample plus N_TAPS shifted delayed copies, saturated, once per sample tick.
// Define ECHO_FEEDBACK_EN to store the saturated output (recirculating echo) instead of the dry input.
module multitap_echo
    import echo_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned N_TAPS = 4
) (
    input logic            sysclk,
    input logic            reset,
    multitap_echo_if.slave bus
);
    localparam int unsigned ACC_W = DATA_W + 4;
    localparam int unsigned IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [IDX_W-1:0]  LAST_TAP = IDX_W'(N_TAPS - 1);
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                   state;
    logic [IDX_W-1:0]         tap_idx;
    logic signed [DATA_W-1:0] x;
    logic signed [ACC_W-1:0]  acc;
    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        fill;

    // Tap whose RAM read was issued last cycle; its word is accumulated this cycle.
    logic                     pend_valid;
    logic                     pend_mute;
    logic                     pend_use_x;
    logic [2:0]               pend_code;

    logic [ADDR_W-1:0]        cur_delay;
    logic [2:0]               cur_code;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        rd_data;
    logic signed [DATA_W-1:0] tap_sample;
    logic signed [ACC_W-1:0]  tap_term;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] y;
    logic                     ram_we;
    logic [DATA_W-1:0]        ram_wdata;

    always_comb begin
        cur_delay  = bus.tap_delay[int'(tap_idx) * ADDR_W +: ADDR_W];
        cur_code   = bus.tap_gain[int'(tap_idx) * 3 +: 3];
        rd_addr    = wr_ptr - cur_delay;
        tap_sample = pend_use_x ? x : signed'(rd_data);
        tap_term   = '0;
        if (pend_valid && !pend_mute) begin
            tap_term = ACC_W'(tap_sample) >>> (pend_code + 3'd1);
        end
        acc_sum    = acc + tap_term;
        y          = DATA_W'(sat_signed(32'(acc), DATA_W));
        ram_we     = (state == WRITE);
`ifdef ECHO_FEEDBACK_EN
        ram_wdata  = y;
`else
        ram_wdata  = x;
`endif
    end

    echo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sysclk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tap_idx       <= '0;
            x             <= '0;
            acc           <= '0;
            wr_ptr        <= '0;
            fill          <= '0;
            pend_valid    <= 1'b0;
            pend_mute     <= 1'b0;
            pend_use_x    <= 1'b0;
            pend_code     <= '0;
            bus.data_out  <= MID;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            pend_valid    <= 1'b0;
            if (bus.sample_tick && state != IDLE) bus.overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (bus.sample_tick) begin
                        x        <= signed'(bus.data_in - MID);
                        acc      <= ACC_W'(signed'(bus.data_in - MID));
                        tap_idx  <= '0;
                        bus.busy <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    acc        <= acc_sum;
                    pend_valid <= 1'b1;
                    pend_use_x <= (cur_delay == '0);
                    // Taps reaching past the written history read stale RAM; silence them.
                    pend_mute  <= (cur_code == GAIN_MUTE) || (cur_delay > fill);
                    pend_code  <= cur_code;
                    if (tap_idx == LAST_TAP) state <= DRAIN;
                    else tap_idx <= tap_idx + 1'b1;
                end
                DRAIN: begin
                    acc   <= acc_sum;
                    state <= WRITE;
                end
                WRITE: begin
                    bus.data_out  <= y + MID;
                    bus.out_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    wr_ptr        <= wr_ptr + 1'b1;
                    if (fill != FILL_MAX) fill <= fill + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multitap_echo.sv
// Directed self-checking bench for multitap_echo (DATA_W=10, ADDR_W=4, N_TAPS=2).
module tb_multitap_echo;
    localparam int unsigned DATA_W = 10;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned N_TAPS = 2;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    multitap_echo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_TAPS(N_TAPS)) bus ();

    multitap_echo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_TAPS(N_TAPS)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_taps(input int d0, input int g0);
        bus.tap_delay = {ADDR_W'(0), ADDR_W'(d0)};
        bus.tap_gain  = {3'd7, 3'(g0)};
    endtask

    // One tick; checks the output value and that out_valid arrives 5 cycles after the tick.
    task automatic do_tick(input logic [9:0] v, input logic [9:0] exp, input string tag);
        int lat;
        lat = 0;
        @(negedge sysclk);
        bus.data_in     = v;
        bus.sample_tick = 1'b1;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge sysclk);
            bus.sample_tick = 1'b0;
            if (bus.out_valid) lat = i;
        end
        chk({tag, " out"}, 32'(bus.data_out), 32'(exp));
        chk({tag, " lat"}, lat, 5);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
    endtask

    task automatic count_valid(input int cycles, output int nv);
        nv = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge sysclk);
            if (bus.out_valid) nv++;
        end
    endtask

    initial begin
        int nv;
        int r;
        int e;
        int hist [40];

        bus.sample_tick = 1'b0;
        bus.data_in     = 10'd512;
        set_taps(0, 7);
        repeat (2) @(negedge sysclk);
        chk("rst data_out", 32'(bus.data_out), 512);
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst overrun", 32'(bus.overrun), 0);
        reset = 1'b0;

        // d=0 uses x directly: y = x + x/2, saturated
        set_taps(0, 0);
        do_tick(10'd1023, 10'd1023, "sat_hi");
        do_tick(10'd0, 10'd0, "sat_lo");
        do_tick(10'd512, 10'd512, "sat_mid");

        // second tick lands while busy
        @(negedge sysclk);
        bus.data_in = 10'd768;
        bus.sample_tick = 1'b1;
        @(negedge sysclk);
        bus.sample_tick = 1'b0;
        @(negedge sysclk);
        bus.sample_tick = 1'b1;
        @(negedge sysclk);
        bus.sample_tick = 1'b0;
        count_valid(20, nv);
        chk("ovr n_valid", nv, 1);
        chk("ovr data_out", 32'(bus.data_out), 896);
        chk("ovr overrun", 32'(bus.overrun), 1);

        // reset in the middle of READ
        set_taps(0, 7);
        do_tick(10'd768, 10'd768, "pre_rst");
        @(negedge sysclk);
        bus.data_in = 10'd640;
        bus.sample_tick = 1'b1;
        @(negedge sysclk);
        bus.sample_tick = 1'b0;
        chk("mid busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("mrst data_out", 32'(bus.data_out), 512);
        chk("mrst out_valid", 32'(bus.out_valid), 0);
        chk("mrst busy", 32'(bus.busy), 0);
        chk("mrst overrun", 32'(bus.overrun), 0);
        @(negedge sysclk);
        reset = 1'b0;
        count_valid(10, nv);
        chk("mrst no_write", nv, 0);
        set_taps(1, 0);
        do_tick(10'd768, 10'd768, "mrst fill0");
        do_tick(10'd512, 10'd640, "mrst slot0");

        // single impulse, tap0 d=3 g=0
        do_reset();
        set_taps(3, 0);
        for (int k = 0; k < 10; k++) begin
            e = 512;
            if (k == 0) e = 768;
            if (k == 3) e = 640;
`ifdef ECHO_FEEDBACK_EN
            if (k == 6) e = 576;
            if (k == 9) e = 544;
`endif
            do_tick((k == 0) ? 10'd768 : 10'd512, 10'(e), $sformatf("echo%0d", k));
        end

        // delay beyond the filled history contributes nothing
        do_reset();
        set_taps(10, 0);
        for (int k = 0; k < 13; k++) begin
            do_tick(10'd768, (k < 10) ? 10'd768 : 10'd896, $sformatf("fill%0d", k));
        end

        // ramp across wr_ptr wrap, tap0 d=15 g=0
        do_reset();
        set_taps(15, 0);
        for (int k = 0; k < 40; k++) begin
            r = k * 7 - 140;
            e = r + ((k >= 15) ? (hist[k-15] >>> 1) : 0);
            if (e > 511) e = 511;
            if (e < -512) e = -512;
`ifdef ECHO_FEEDBACK_EN
            hist[k] = e;
`else
            hist[k] = r;
`endif
            do_tick(10'(r + 512), 10'(e + 512), $sformatf("ramp%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
